corelet_ostage: RTL

Parametrised output stage for the corelet, generalising the fixed accumulate/ReLU/OFIFO path to any column count, psum width and buffer depth. It sits between the MAC array south outputs and the PSUM SRAM write path. In weight-stationary mode it holds an on-chip bank of per-column partial-sum accumulators, addressed per pass. In output-stationary mode it passes outputs straight through. Each column has its own FIFO to absorb systolic skew. Complete rows go out over a valid/ready handshake.

---
 rtl/corelet_ostage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/corelet_ostage.sv
// Corelet output stage: per-column accumulate or pass-through, optional ReLU,
// per-column skew FIFOs, and row-wide valid/ready drain toward the PSUM SRAM.
module corelet_ostage #(
    parameter int col        = 8,
    parameter int psum_bw    = 16,
    parameter int acc_depth  = 16,
    parameter int fifo_depth = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         execution_mode,
    input  logic [col*psum_bw-1:0]       in_psum,
    input  logic [col-1:0]               in_valid,
    input  logic [$clog2(acc_depth)-1:0] acc_addr,
    input  logic                         acc_first,
    input  logic                         acc_last,
    input  logic                         relu_en,
    output logic [col*psum_bw-1:0]       out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         full,
    output logic                         overflow
);

    localparam int AW = $clog2(acc_depth);
    localparam int PW = $clog2(fifo_depth);
    localparam int TW = AW + 4;
    localparam logic [PW:0] FIFO_FULL = (PW+1)'(fifo_depth);
    localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    logic [TW-1:0]  tag_live;
    logic [TW-1:0]  tag_col [col];
    logic [col-1:0] col_nempty;
    logic [col-1:0] col_full;
    logic [col-1:0] col_drop;
    logic           pop;
    logic           overflow_reg;

    assign tag_live   = {execution_mode, acc_addr, acc_first, acc_last, relu_en};
    assign tag_col[0] = tag_live;

    // Tag follows the systolic skew: column gi sees the tag from gi cycles ago.
    genvar gi;
    generate
        for (gi = 1; gi < col; gi++) begin : g_tag
            logic [TW-1:0] tag_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) tag_reg <= '0;
                else       tag_reg <= tag_col[gi-1];
            end
            assign tag_col[gi] = tag_reg;
        end
    endgenerate

    assign out_valid = &col_nempty;
    assign pop       = out_valid && out_ready;
    assign full      = |col_full;
    assign overflow  = overflow_reg;

    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            logic                       t_mode;
            logic [AW-1:0]              t_addr;
            logic                       t_first;
            logic                       t_last;
            logic                       t_relu;
            logic signed [psum_bw-1:0]  psum;
            logic signed [psum_bw-1:0]  acc_rd;
            logic signed [psum_bw:0]    wide_sum;
            logic signed [psum_bw-1:0]  sat_sum;
            logic signed [psum_bw-1:0]  ws_sum;
            logic signed [psum_bw-1:0]  pre_val;
            logic signed [psum_bw-1:0]  push_val;
            logic                       acc_we;
            logic                       push_req;
            logic                       do_push;
            logic                       is_full;
            logic                       nonempty;
            logic signed [psum_bw-1:0]  acc_mem [acc_depth];
            logic [psum_bw-1:0]         fifo_mem [fifo_depth];
            logic [PW-1:0]              wr_ptr_reg;
            logic [PW-1:0]              rd_ptr_reg;
            logic [PW:0]                count_reg;

            assign {t_mode, t_addr, t_first, t_last, t_relu} = tag_col[gi];
            assign psum     = in_psum[gi*psum_bw +: psum_bw];
            assign acc_rd   = acc_mem[t_addr];
            assign wide_sum = {acc_rd[psum_bw-1], acc_rd} + {psum[psum_bw-1], psum};

            // Overflow iff the extra sign bit disagrees with the result sign.
            always_comb begin
                sat_sum = wide_sum[psum_bw-1:0];
                if (wide_sum[psum_bw] != wide_sum[psum_bw-1])
                    sat_sum = wide_sum[psum_bw] ? SAT_MIN : SAT_MAX;
            end

            assign ws_sum   = t_first ? psum : sat_sum;
            assign pre_val  = t_mode ? psum : ws_sum;
            assign push_val = (t_relu && pre_val[psum_bw-1]) ? '0 : pre_val;
            assign acc_we   = in_valid[gi] && !t_mode;
            assign push_req = in_valid[gi] && (t_mode || t_last);

            assign is_full  = (count_reg == FIFO_FULL);
            assign nonempty = (count_reg != '0);
            assign do_push  = push_req && (!is_full || pop);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < acc_depth; i++) acc_mem[i] <= '0;
                end else if (acc_we) begin
                    acc_mem[t_addr] <= ws_sum;
                end
            end

            always_ff @(posedge clk) begin
                if (do_push) fifo_mem[wr_ptr_reg] <= push_val;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, pop};
                end
            end

            assign col_nempty[gi] = nonempty;
            assign col_full[gi]   = is_full;
            assign col_drop[gi]   = push_req && is_full && !pop;
            // Empty columns show zero so stale memory never leaks after reset.
            assign out_data[gi*psum_bw +: psum_bw] = nonempty ? fifo_mem[rd_ptr_reg] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          overflow_reg <= 1'b0;
        else if (|col_drop) overflow_reg <= 1'b1;
    end

endmodule
